// File: rtl/mem_read_sched.sv
// mem_read_sched: round-robin arbiter for the shared packet-memory read path.
// It chases the block chain to EOP and stops a packet on a stall or on a block-count limit.
module mem_read_sched #(
   parameter int NUM_PORTS  = 4,
   parameter int TIMEOUT    = 8,
   parameter int MAX_BLOCKS = 32,
   parameter int ADDR_W     = 8,
   parameter int BLOCK_BITS = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_PORTS-1:0]        req_i,
   input  logic [NUM_PORTS*ADDR_W-1:0] head_addr_i,
   output logic [NUM_PORTS-1:0]        grant_o,
   output logic                        rd_re_o,
   output logic                        rd_start_o,
   output logic [ADDR_W-1:0]           rd_start_addr_o,
   input  logic [BLOCK_BITS-1:0]       rd_data_i,
   input  logic                        rd_valid_i,
   input  logic                        rd_end_i,
   output logic [BLOCK_BITS-1:0]       out_data_o,
   output logic [NUM_PORTS-1:0]        out_valid_o,
   output logic                        out_last_o,
   output logic                        abort_o,
   output logic                        busy_o
);
   localparam int PW  = $clog2(NUM_PORTS);
   localparam int PW1 = PW + 1;
   localparam int BW  = $clog2(MAX_BLOCKS + 1);
   localparam int WW  = $clog2(TIMEOUT + 1);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t state, state_nx;
   logic [PW-1:0] rr_ptr, cur_port, pick, nxt_ptr;
   logic [NUM_PORTS-1:0] rot;
   logic [PW1-1:0] sum;
   logic [BW-1:0] blk_cnt;
   logic [WW-1:0] wd_cnt;
   logic start, lim, tmo, fin, blk;
   // rotate requests so bit 0 is rr_ptr; the lowest set bit wins
   always_comb begin
      rot = NUM_PORTS'({req_i, req_i} >> rr_ptr);
      sum = {1'b0, rr_ptr};
      for (int i = NUM_PORTS - 1; i >= 0; i--)
         if (rot[i]) sum = {1'b0, rr_ptr} + PW1'(i);
      pick = PW'(sum >= PW1'(NUM_PORTS) ? sum - PW1'(NUM_PORTS) : sum);
   end
   assign nxt_ptr = (cur_port == PW'(NUM_PORTS - 1)) ? '0 : cur_port + 1'b1;
   assign start   = rst_n && state == IDLE && |req_i;
   assign blk     = state == WAIT && rd_valid_i;
   assign lim     = blk && !rd_end_i && blk_cnt == BW'(MAX_BLOCKS - 1);
   assign tmo     = state == WAIT && !rd_valid_i && wd_cnt == WW'(TIMEOUT - 1);
   assign fin     = blk && (rd_end_i || lim);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = (state == IDLE) ? (|req_i ? WAIT : IDLE) : ((fin || tmo) ? IDLE : WAIT);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rr_ptr   <= '0;
         cur_port <= '0;
         blk_cnt  <= '0;
         wd_cnt   <= '0;
      end else if (start) begin
         cur_port <= pick;
         blk_cnt  <= '0;
         wd_cnt   <= '0;
      end else if (state == WAIT) begin
         blk_cnt <= rd_valid_i ? blk_cnt + 1'b1 : blk_cnt;
         wd_cnt  <= rd_valid_i ? '0 : wd_cnt + 1'b1;
         if (fin || tmo) rr_ptr <= nxt_ptr;
      end
   always_comb begin
      grant_o         = start ? NUM_PORTS'(1) << pick : '0;
      rd_start_o      = start;
      rd_re_o         = start || (blk && !rd_end_i && !lim);
      rd_start_addr_o = start ? ADDR_W'(head_addr_i >> (pick * ADDR_W)) : '0;
      out_data_o      = rst_n ? rd_data_i : '0;
      out_valid_o     = blk ? NUM_PORTS'(1) << cur_port : '0;
      out_last_o      = fin;
      abort_o         = tmo || lim;
      busy_o          = state == WAIT;
   end
endmodule

// File: tb/tb_mem_read_sched.sv
// tb_mem_read_sched: drives mem_read_sched with a 2-cycle linked-block memory and checks
// every cycle against a transaction-level scheduler model plus literal event timelines.
module tb_mem_read_sched;
   localparam int N = 4, TO = 8, MB = 32, AW = 8, BB = 32;
   logic clk = 0, rst_n = 0;
   logic [N-1:0] req_i = '0;
   logic [N*AW-1:0] head_addr_i = '0;
   logic [N-1:0] grant_o, out_valid_o;
   logic rd_re_o, rd_start_o, out_last_o, abort_o, busy_o;
   logic [AW-1:0] rd_start_addr_o;
   logic [BB-1:0] rd_data_i = '0, out_data_o;
   logic rd_valid_i = 0, rd_end_i = 0;
   int n_chk = 0, n_fail = 0, cyc = 0;

   mem_read_sched #(.NUM_PORTS(N), .TIMEOUT(TO), .MAX_BLOCKS(MB), .ADDR_W(AW), .BLOCK_BITS(BB)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .head_addr_i(head_addr_i), .grant_o(grant_o),
      .rd_re_o(rd_re_o), .rd_start_o(rd_start_o), .rd_start_addr_o(rd_start_addr_o),
      .rd_data_i(rd_data_i), .rd_valid_i(rd_valid_i), .rd_end_i(rd_end_i), .out_data_o(out_data_o),
      .out_valid_o(out_valid_o), .out_last_o(out_last_o), .abort_o(abort_o), .busy_o(busy_o));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [BB-1:0] dat(input logic [AW-1:0] a);
      return {24'hDA7A00, a};
   endfunction

   // linked-block memory behind the read controller: data returns 2 cycles after re
   logic [AW-1:0] nxt [256];
   logic eop [256];
   bit mute = 0, auto_pop = 0, p0_v = 0, p1_v = 0;
   logic [AW-1:0] last_a = '0, p0_a = '0, p1_a = '0;
   logic [N-1:0] last_grant = '0;

   always @(negedge clk) begin
      if (rd_re_o && !mute) begin
         p0_a = rd_start_o ? rd_start_addr_o : nxt[last_a];
         last_a = p0_a;
         p0_v = 1;
      end else p0_v = 0;
   end

   always @(posedge clk) begin
      cyc++;
      #1;
      rd_valid_i = p1_v;
      rd_end_i   = p1_v && eop[p1_a];
      rd_data_i  = p1_v ? dat(p1_a) : '0;
      p1_v = p0_v;
      p1_a = p0_a;
   end

   // event logs taken from the DUT, checked against hand-computed timelines
   int g_cyc[$], v_cyc[$], a_cyc[$];
   logic [N-1:0] g_port[$], v_port[$];
   logic [AW-1:0] g_addr[$];
   logic v_last[$];
   logic [BB-1:0] v_data[$];

   task automatic clear_logs();
      g_cyc.delete(); v_cyc.delete(); a_cyc.delete(); g_port.delete();
      v_port.delete(); g_addr.delete(); v_last.delete(); v_data.delete();
   endtask

   // scheduler model: one packet at a time, rotating priority, watchdog and block cap
   bit m_busy = 0;
   int m_port = 0, m_blk = 0, m_quiet = 0, m_rr = 0;

   always @(negedge clk) begin
      logic [N-1:0] eg, ev;
      logic es, ere, el, ea, eb;
      logic [AW-1:0] eaddr;
      logic [BB-1:0] ed;
      int p;
      eg = '0; ev = '0; es = 0; ere = 0; el = 0; ea = 0; eb = 0; eaddr = '0;
      ed = rst_n ? rd_data_i : '0;
      if (!rst_n) begin
         m_busy = 0; m_rr = 0; m_port = 0;
      end else if (!m_busy) begin
         p = -1;
         for (int k = 0; k < N; k++)
            if (p < 0 && req_i[(m_rr + k) % N]) p = (m_rr + k) % N;
         if (p >= 0) begin
            eg[p] = 1; es = 1; ere = 1; eaddr = head_addr_i[p*AW +: AW];
            m_busy = 1; m_port = p; m_blk = 0; m_quiet = 0;
         end
      end else begin
         eb = 1;
         if (rd_valid_i) begin
            m_blk++;
            m_quiet = 0;
            ev[m_port] = 1;
            el = rd_end_i || m_blk == MB;
            ea = !rd_end_i && m_blk == MB;
            ere = !el;
            if (el) begin m_busy = 0; m_rr = (m_port + 1) % N; end
         end else begin
            m_quiet++;
            if (m_quiet == TO) begin ea = 1; m_busy = 0; m_rr = (m_port + 1) % N; end
         end
      end
      chk("grant_o", grant_o, eg);
      chk("rd_start_o", rd_start_o, es);
      chk("rd_re_o", rd_re_o, ere);
      if (es) chk("rd_start_addr_o", rd_start_addr_o, eaddr);
      chk("out_valid_o", out_valid_o, ev);
      chk("out_data_o", out_data_o, ed);
      if (ev != 0) chk("out_last_o", out_last_o, el);
      chk("abort_o", abort_o, ea);
      chk("busy_o", busy_o, eb);
      last_grant = grant_o;
      if (grant_o != 0) begin g_cyc.push_back(cyc); g_port.push_back(grant_o); g_addr.push_back(rd_start_addr_o); end
      if (out_valid_o != 0) begin
         v_cyc.push_back(cyc); v_port.push_back(out_valid_o);
         v_last.push_back(out_last_o); v_data.push_back(out_data_o);
      end
      if (abort_o) a_cyc.push_back(cyc);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (auto_pop) req_i = req_i & ~last_grant;
      end
   endtask

   task automatic do_reset();
      rst_n = 0;
      step(2);
      rst_n = 1;
      step(1);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int t0, t1;
      for (int i = 0; i < 256; i++) begin nxt[i] = '0; eop[i] = 1; end
      nxt[5] = 9; eop[5] = 0; nxt[9] = 2; eop[9] = 0;
      nxt[7] = 7; eop[7] = 0;
      // reset: requests held during reset must not be granted
      req_i = 4'b0101;
      step(3);
      chk("reset_busy", busy_o, 0);
      chk("reset_grant", grant_o, 0);
      req_i = '0;
      rst_n = 1;
      step(2);

      // single port, 3-block chain 5->9->2
      head_addr_i[0*AW +: AW] = 8'd5;
      auto_pop = 1;
      clear_logs();
      req_i = 4'b0001;
      t0 = cyc;
      step(10);
      chk("t1_grant_count", g_cyc.size(), 1);
      chk("t1_grant_cyc", g_cyc[0], t0);
      chk("t1_grant_port", g_port[0], 4'b0001);
      chk("t1_start_addr", g_addr[0], 8'd5);
      chk("t1_block_count", v_cyc.size(), 3);
      if (v_cyc.size() == 3)
         for (int k = 0; k < 3; k++) begin
            chk("t1_block_cyc", v_cyc[k], t0 + 2 + 2 * k);
            chk("t1_block_last", v_last[k], k == 2);
         end
      chk("t1_data1", v_data[1], 32'hDA7A0009);
      chk("t1_data2", v_data[2], 32'hDA7A0002);

      // four ports continuously requesting 1-block packets
      do_reset();
      for (int p = 0; p < N; p++) head_addr_i[p*AW +: AW] = AW'(20 + p);
      auto_pop = 0;
      clear_logs();
      req_i = 4'b1111;
      t0 = cyc;
      step(13);
      req_i = '0;
      step(6);
      chk("t2_grant_count", g_cyc.size(), 5);
      if (g_cyc.size() == 5)
         for (int k = 0; k < 5; k++) begin
            chk("t2_grant_port", g_port[k], 4'b0001 << (k % 4));
            chk("t2_grant_cyc", g_cyc[k], t0 + 3 * k);
            chk("t2_grant_addr", g_addr[k], 20 + (k % 4));
         end

      // port 2 served, then ports 2 and 3 together: 3 wins
      do_reset();
      head_addr_i[2*AW +: AW] = 8'd30;
      head_addr_i[3*AW +: AW] = 8'd31;
      auto_pop = 1;
      clear_logs();
      req_i = 4'b0100;
      step(6);
      req_i = 4'b1100;
      step(12);
      chk("t3_grant_count", g_port.size(), 3);
      chk("t3_grant0", g_port[0], 4'b0100);
      chk("t3_grant1", g_port[1], 4'b1000);
      chk("t3_grant2", g_port[2], 4'b0100);

      // watchdog: memory silent, two requesters
      do_reset();
      head_addr_i[0*AW +: AW] = 8'd5;
      head_addr_i[1*AW +: AW] = 8'd6;
      mute = 1;
      clear_logs();
      req_i = 4'b0011;
      t0 = cyc;
      step(22);
      mute = 0;
      chk("t4_abort_count", a_cyc.size(), 2);
      chk("t4_abort0", a_cyc[0], t0 + 8);
      chk("t4_abort1", a_cyc[1], t0 + 17);
      chk("t4_grant_count", g_cyc.size(), 2);
      chk("t4_grant1_cyc", g_cyc[1], t0 + 9);
      chk("t4_grant1_port", g_port[1], 4'b0010);

      // self-looping chain hits the block cap
      do_reset();
      head_addr_i[1*AW +: AW] = 8'd7;
      clear_logs();
      req_i = 4'b0010;
      t0 = cyc;
      step(75);
      chk("t5_block_count", v_cyc.size(), 32);
      chk("t5_block_port", v_port[0], 4'b0010);
      chk("t5_last_cyc", v_cyc[31], t0 + 64);
      chk("t5_last31", v_last[31], 1);
      chk("t5_last30", v_last[30], 0);
      chk("t5_abort_count", a_cyc.size(), 1);
      chk("t5_abort_cyc", a_cyc[0], t0 + 64);
      chk("t5_grant_count", g_cyc.size(), 1);

      // reset after block 1 of 3; priority pointer must return to port 0
      clear_logs();
      req_i = 4'b0001;
      t0 = cyc;
      step(3);
      rst_n = 0;
      req_i = 4'b0101;
      #1;
      chk("t6_rst_busy", busy_o, 0);
      chk("t6_rst_grant", grant_o, 0);
      step(3);
      rst_n = 1;
      t1 = cyc;
      step(16);
      chk("t6_block_count", v_cyc.size(), 1 + 3 + 1);
      chk("t6_abort_count", a_cyc.size(), 0);
      chk("t6_grant_count", g_cyc.size(), 3);
      chk("t6_regrant_cyc", g_cyc[1], t1);
      chk("t6_regrant_port", g_port[1], 4'b0001);
      chk("t6_regrant_addr", g_addr[1], 8'd5);
      chk("t6_third_port", g_port[2], 4'b0100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
